// File: rtl/warp_pkg.sv
// Shared definitions for the perspective-warp engine: FSM encoding, default
// widths and the {y,x} address-pack helper.
package warp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV_GO,
    S_DIV_WAIT,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int DEF_XW    = 10;
  localparam int DEF_YW    = 9;
  localparam int DEF_ACC_W = 48;

  // Line pitch is 2^xw, so the y coordinate sits directly above x.
  function automatic logic [31:0] pack_addr(input logic [31:0] y, input logic [31:0] x,
                                            input int xw);
    return (y << xw) | x;
  endfunction

endpackage

// File: rtl/warp_divider.sv
// Signed restoring divider: one quotient bit per cycle, truncates toward zero.
// ready_o rises W+2 cycles after the start_i cycle and drops on the next start_i.
module warp_divider
  import warp_pkg::*;
#(
  parameter int W = DEF_ACC_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [W-1:0] num_i,
  input  logic [W-1:0] den_i,
  output logic [W-1:0] quot_o,
  output logic         ready_o
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, dvd_q, dvs_q, quot_q;
  logic [CW-1:0] cnt_q;
  logic          neg_q, run_q, ready_q;
  logic [W:0]    rem_sh, rem_sub;

  // Magnitudes are divided unsigned; the dividend register doubles as the quotient.
  assign rem_sh  = {rem_q, dvd_q[W-1]};
  assign rem_sub = rem_sh - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      run_q   <= 1'b0;
      ready_q <= 1'b0;
    end else if (start_i) begin
      rem_q   <= '0;
      dvd_q   <= num_i[W-1] ? -num_i : num_i;
      dvs_q   <= den_i[W-1] ? -den_i : den_i;
      neg_q   <= num_i[W-1] ^ den_i[W-1];
      cnt_q   <= CW'(W);
      run_q   <= 1'b1;
      ready_q <= 1'b0;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        if (!rem_sub[W]) begin
          rem_q <= rem_sub[W-1:0];
          dvd_q <= {dvd_q[W-2:0], 1'b1};
        end else begin
          rem_q <= rem_sh[W-1:0];
          dvd_q <= {dvd_q[W-2:0], 1'b0};
        end
        cnt_q <= cnt_q - CW'(1);
      end else begin
        quot_q  <= neg_q ? -dvd_q : dvd_q;
        run_q   <= 1'b0;
        ready_q <= 1'b1;
      end
    end
  end

  assign quot_o  = quot_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/perspective_warp_engine.sv
// Raster-scans the destination frame, maps each pixel through the homography
// and copies the matching source pixel (or FILL_PIX when out of range).
module perspective_warp_engine
  import warp_pkg::*;
#(
  parameter int              XW       = DEF_XW,
  parameter int              YW       = DEF_YW,
  parameter int              DST_W    = 640,
  parameter int              DST_H    = 480,
  parameter int              SRC_W    = 640,
  parameter int              SRC_H    = 480,
  parameter int              PIX_W    = 36,
  parameter int              COEF_W   = 42,
  parameter int              ACC_W    = DEF_ACC_W,
  parameter int              RD_LAT   = 2,
  parameter logic [PIX_W-1:0] FILL_PIX = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [COEF_W-1:0] p1,
  input  logic [COEF_W-1:0] p2,
  input  logic [COEF_W-1:0] p3,
  input  logic [COEF_W-1:0] p4,
  input  logic [COEF_W-1:0] p5,
  input  logic [COEF_W-1:0] p6,
  input  logic [COEF_W-1:0] p7,
  input  logic [COEF_W-1:0] p8,
  input  logic [COEF_W-1:0] p9,
  output logic [XW+YW-1:0]  src_addr,
  output logic              src_re,
  input  logic [PIX_W-1:0]  src_data,
  output logic [XW+YW-1:0]  dst_addr,
  output logic [PIX_W-1:0]  dst_data,
  output logic              dst_we,
  output logic              busy,
  output logic              done
);

  localparam int AW = XW + YW;
  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int SW = AW + 2;

  state_e            state_q, state_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [COEF_W-1:0] p_in   [9];
  logic [COEF_W-1:0] coef_q [9];
  logic [ACC_W-1:0]  cx_q, cy_q, cd_q, rx_q, ry_q, rd_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ACC_W-1:0]  num_x, num_y, den, qx, qy;
  logic              rdy_x, rdy_y, div_go;
  logic              idle_s, accept, is_issue, row_end, last_px, oob_s;
  logic [SW-1:0]     dl_q [RD_LAT];
  logic [SW-1:0]     dl_in;

  function automatic logic [ACC_W-1:0] sext(input logic [COEF_W-1:0] c);
    return {{(ACC_W - COEF_W){c[COEF_W-1]}}, c};
  endfunction

  assign p_in     = '{p1, p2, p3, p4, p5, p6, p7, p8, p9};
  assign idle_s   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept   = idle_s && start && !abort;
  assign is_issue = (state_q == S_ISSUE);
  assign div_go   = (state_q == S_DIV_GO);
  assign row_end  = (x_q == XW'(DST_W - 1));
  assign last_px  = row_end && (y_q == YW'(DST_H - 1));

  assign num_x = cx_q + rx_q;
  assign num_y = cy_q + ry_q;
  assign den   = cd_q + rd_q;

  // Sign bit first so the unsigned upper-bound compares only see non-negative quotients.
  assign oob_s = (den == '0) || qx[ACC_W-1] || qy[ACC_W-1] ||
                 (qx >= ACC_W'(SRC_W)) || (qy >= ACC_W'(SRC_H));

  warp_divider #(.W(ACC_W)) u_div_x (
    .clk(clk), .reset(reset), .start_i(div_go),
    .num_i(num_x), .den_i(den), .quot_o(qx), .ready_o(rdy_x)
  );

  warp_divider #(.W(ACC_W)) u_div_y (
    .clk(clk), .reset(reset), .start_i(div_go),
    .num_i(num_y), .den_i(den), .quot_o(qy), .ready_o(rdy_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (!idle_s && abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: if (accept) state_d = S_LOAD;
        S_LOAD:         state_d = S_DIV_GO;
        S_DIV_GO:       state_d = S_DIV_WAIT;
        S_DIV_WAIT:     if (rdy_x && rdy_y) state_d = S_ISSUE;
        S_ISSUE: begin
          state_d = last_px ? S_DRAIN : S_DIV_GO;
          drain_d = '0;
        end
        S_DRAIN: begin
          if (drain_q == DW'(RD_LAT - 1)) state_d = S_DONE;
          else drain_d = drain_q + DW'(1);
        end
        default:        state_d = S_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < 9; gi++) begin : g_coef
    always_ff @(posedge clk) begin
      if (reset)       coef_q[gi] <= '0;
      else if (accept) coef_q[gi] <= p_in[gi];
    end
  end

  // Column accumulators restart each row; row bases advance by the y coefficients.
  always_ff @(posedge clk) begin
    if (reset) begin
      {cx_q, cy_q, cd_q, rx_q, ry_q, rd_q} <= '0;
      x_q <= '0;
      y_q <= '0;
    end else if (state_q == S_LOAD) begin
      {cx_q, cy_q, cd_q} <= '0;
      rx_q <= sext(coef_q[2]);
      ry_q <= sext(coef_q[5]);
      rd_q <= sext(coef_q[8]);
      x_q  <= '0;
      y_q  <= '0;
    end else if (is_issue) begin
      if (row_end) begin
        {cx_q, cy_q, cd_q} <= '0;
        rx_q <= rx_q + sext(coef_q[1]);
        ry_q <= ry_q + sext(coef_q[4]);
        rd_q <= rd_q + sext(coef_q[7]);
        x_q  <= '0;
        y_q  <= y_q + YW'(1);
      end else begin
        cx_q <= cx_q + sext(coef_q[0]);
        cy_q <= cy_q + sext(coef_q[3]);
        cd_q <= cd_q + sext(coef_q[6]);
        x_q  <= x_q + XW'(1);
      end
    end
  end

  // Delay line entry: {valid, oob, dst_addr}, aligned with the source read latency.
  assign dl_in = is_issue ? {1'b1, oob_s, AW'(pack_addr(32'(y_q), 32'(x_q), XW))} : '0;

  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_dl
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (reset || abort) dl_q[gi] <= '0;
        else                dl_q[gi] <= dl_in;
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (reset || abort) dl_q[gi] <= '0;
        else                dl_q[gi] <= dl_q[gi-1];
      end
    end
  end

  assign src_re   = is_issue && !oob_s;
  assign src_addr = is_issue ? AW'(pack_addr(32'(qy[YW-1:0]), 32'(qx[XW-1:0]), XW)) : '0;
  assign dst_we   = dl_q[RD_LAT-1][SW-1];
  assign dst_addr = dl_q[RD_LAT-1][AW-1:0];
  assign dst_data = !dst_we ? '0 : (dl_q[RD_LAT-1][AW] ? FILL_PIX : src_data);
  assign busy     = !idle_s;
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_perspective_warp_engine.sv
// Scoreboard bench for perspective_warp_engine on a 4x3 frame with src_data = address.
module tb_perspective_warp_engine;

  localparam int XW = 2, YW = 2, AW = 4;
  localparam int DST_W = 4, DST_H = 3, SRC_W = 4, SRC_H = 3;
  localparam int PIX_W = 36, COEF_W = 42, ACC_W = 48, RD_LAT = 2;
  localparam logic [PIX_W-1:0] FILL = 36'h000000F0F;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [COEF_W-1:0] pv [9];
  logic [AW-1:0] src_addr, dst_addr;
  logic src_re, dst_we, busy, done;
  logic [PIX_W-1:0] src_data, dst_data;
  logic [PIX_W-1:0] pipe [RD_LAT];

  int pass_cnt = 0, total_cnt = 0;
  longint coef [9];
  logic [AW-1:0]    exp_addr_q[$], obs_addr_q[$], exp_src_q[$], obs_src_q[$];
  logic [PIX_W-1:0] exp_data_q[$], obs_data_q[$];
  bit timed_out;

  perspective_warp_engine #(
    .XW(XW), .YW(YW), .DST_W(DST_W), .DST_H(DST_H), .SRC_W(SRC_W), .SRC_H(SRC_H),
    .PIX_W(PIX_W), .COEF_W(COEF_W), .ACC_W(ACC_W), .RD_LAT(RD_LAT), .FILL_PIX(FILL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .p1(pv[0]), .p2(pv[1]), .p3(pv[2]), .p4(pv[3]), .p5(pv[4]),
    .p6(pv[5]), .p7(pv[6]), .p8(pv[7]), .p9(pv[8]),
    .src_addr(src_addr), .src_re(src_re), .src_data(src_data),
    .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Source memory returns its own address, RD_LAT cycles after src_re.
  always @(posedge clk) begin
    pipe[0] <= src_re ? {{(PIX_W - AW){1'b0}}, src_addr} : 36'hBAD0BAD0B;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign src_data = pipe[RD_LAT-1];

  task automatic set_identity;
    coef = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  endtask

  // Drive coefficients, push the reference results, pulse start.
  task automatic start_frame;
    logic [63:0] t;
    longint d, nx, ny, qx, qy;
    bit oob;
    for (int i = 0; i < 9; i++) begin
      t = coef[i];
      pv[i] = t[COEF_W-1:0];
    end
    exp_addr_q.delete(); exp_data_q.delete(); exp_src_q.delete();
    obs_addr_q.delete(); obs_data_q.delete(); obs_src_q.delete();
    for (int y = 0; y < DST_H; y++) begin
      for (int x = 0; x < DST_W; x++) begin
        d  = coef[6] * x + coef[7] * y + coef[8];
        nx = coef[0] * x + coef[1] * y + coef[2];
        ny = coef[3] * x + coef[4] * y + coef[5];
        oob = (d == 0);
        qx = 0; qy = 0;
        if (!oob) begin
          qx = nx / d;
          qy = ny / d;
          oob = (qx < 0) || (qx >= SRC_W) || (qy < 0) || (qy >= SRC_H);
        end
        exp_addr_q.push_back(AW'(y * (1 << XW) + x));
        exp_data_q.push_back(oob ? FILL : PIX_W'(qy * (1 << XW) + qx));
        if (!oob) exp_src_q.push_back(AW'(qy * (1 << XW) + qx));
      end
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Record DUT writes and reads until done (or 200 cycles after an abort).
  task automatic capture(input int start_at, input int abort_after);
    int ab_at = -1;
    timed_out = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (dst_we) begin
        obs_addr_q.push_back(dst_addr);
        obs_data_q.push_back(dst_data);
      end
      if (src_re) obs_src_q.push_back(src_addr);
      if (done || (ab_at >= 0 && c >= ab_at + 200)) begin
        timed_out = 1'b0;
        break;
      end
      start = (c == start_at);
      abort = (abort_after > 0) && (ab_at < 0) && (obs_addr_q.size() == abort_after);
      if (abort) ab_at = c;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_status: busy/done got %b/%b, required 0/0", busy, done);
    else pass_cnt++;
    total_cnt++;
    if (dst_we !== 1'b0 || src_re !== 1'b0) $display("FAIL reset_strobes: dst_we/src_re got %b/%b, required 0/0", dst_we, src_re);
    else pass_cnt++;
    total_cnt++;
    if ({src_addr, dst_addr, dst_data} !== '0) $display("FAIL reset_buses: src_addr/dst_addr/dst_data got %h/%h/%h, required 0", src_addr, dst_addr, dst_data);
    else pass_cnt++;
    $display("reset checked: busy=%b done=%b dst_we=%b", busy, done, dst_we);
  endtask

  task automatic test_patterns;
    string  names [5] = '{"identity", "scale2", "shift", "zero", "divide"};
    longint tbl [5][9] = '{'{1, 0, 0, 0, 1, 0, 0, 0, 1},
                           '{2, 0, 0, 0, 2, 0, 0, 0, 1},
                           '{1, 0, -2, 0, 1, 0, 0, 0, 1},
                           '{0, 0, 0, 0, 0, 0, 0, 0, 0},
                           '{1, 0, -1, 0, 2, 0, 0, 0, 2}};
    logic [AW-1:0] ea, oa;
    logic [PIX_W-1:0] ed, od;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 9; i++) coef[i] = tbl[k][i];
      start_frame();
      capture(-1, 0);
      total_cnt++;
      if (timed_out) $display("FAIL %s_done: done not seen within cycle budget, required done=1", names[k]);
      else pass_cnt++;
      total_cnt++;
      if (obs_addr_q.size() != exp_addr_q.size()) $display("FAIL %s_writes: got %0d writes, required %0d", names[k], obs_addr_q.size(), exp_addr_q.size());
      else pass_cnt++;
      while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
        oa = obs_addr_q.pop_front(); od = obs_data_q.pop_front();
        ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
        total_cnt++;
        if (oa !== ea || od !== ed) $display("FAIL %s_pix: addr/data got %h/%h, required %h/%h", names[k], oa, od, ea, ed);
        else begin
          pass_cnt++;
          $display("%s write addr=%h data=%h", names[k], oa, od);
        end
      end
      total_cnt++;
      if (obs_src_q.size() != exp_src_q.size()) $display("FAIL %s_reads: got %0d src_re, required %0d", names[k], obs_src_q.size(), exp_src_q.size());
      else pass_cnt++;
      while (obs_src_q.size() > 0 && exp_src_q.size() > 0) begin
        oa = obs_src_q.pop_front(); ea = exp_src_q.pop_front();
        total_cnt++;
        if (oa !== ea) $display("FAIL %s_read_addr: got %h, required %h", names[k], oa, ea);
        else pass_cnt++;
      end
      total_cnt++;
      if (done !== 1'b1 || busy !== 1'b0) $display("FAIL %s_end: done/busy got %b/%b, required 1/0", names[k], done, busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort;
    logic [AW-1:0] ea, oa;
    logic [PIX_W-1:0] ed, od;
    set_identity();
    start_frame();
    capture(-1, 5);
    total_cnt++;
    if (obs_addr_q.size() != 5) $display("FAIL abort_writes: got %0d writes, required 5", obs_addr_q.size());
    else pass_cnt++;
    while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
      oa = obs_addr_q.pop_front(); od = obs_data_q.pop_front();
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
      total_cnt++;
      if (oa !== ea || od !== ed) $display("FAIL abort_pix: addr/data got %h/%h, required %h/%h", oa, od, ea, ed);
      else begin
        pass_cnt++;
        $display("abort write addr=%h data=%h", oa, od);
      end
    end
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_status: busy/done got %b/%b, required 0/0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] ea, oa;
    logic [PIX_W-1:0] ed, od;
    set_identity();
    start_frame();
    capture(100, 0);
    total_cnt++;
    if (timed_out) $display("FAIL b2b_done: done not seen within cycle budget, required done=1");
    else pass_cnt++;
    total_cnt++;
    if (obs_addr_q.size() != 12) $display("FAIL b2b_writes: got %0d writes, required 12", obs_addr_q.size());
    else pass_cnt++;
    while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
      oa = obs_addr_q.pop_front(); od = obs_data_q.pop_front();
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
      total_cnt++;
      if (oa !== ea || od !== ed) $display("FAIL b2b_pix: addr/data got %h/%h, required %h/%h", oa, od, ea, ed);
      else begin
        pass_cnt++;
        $display("b2b write addr=%h data=%h", oa, od);
      end
    end
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_end: done/busy got %b/%b, required 1/0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int n_we = 0;
    set_identity();
    start_frame();
    repeat (20) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL midrst_busy: busy got %b, required 1", busy);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({busy, done, dst_we, src_re} !== 4'b0 || {src_addr, dst_addr, dst_data} !== '0)
      $display("FAIL midrst_outputs: busy/done/we/re got %b%b%b%b buses %h/%h/%h, required all 0",
               busy, done, dst_we, src_re, src_addr, dst_addr, dst_data);
    else pass_cnt++;
    reset = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (dst_we) n_we++;
    end
    total_cnt++;
    if (n_we != 0 || busy !== 1'b0) $display("FAIL midrst_quiet: got %0d writes busy=%b, required 0 writes busy=0", n_we, busy);
    else pass_cnt++;
    $display("mid-frame reset: writes after reset=%0d", n_we);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) pv[i] = '0;
    test_reset();
    test_patterns();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
